// File: rtl/sram_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_share_arbiter_if
// Bundles the two requester ports, the flush/init status pair and the RAM
// macro pins of sram_share_arbiter.
//   slave  : arbiter side (requests in, grants/read data out, drives RAM pins)
//   master : environment side (requesters + RAM model)
// Signals:
//   ReqX_SI/WeX_SI/AddrX_DI/WDataX_DI/BEnX_SI  requester X access
//   GntX_SO                                     access accepted this cycle
//   RValidX_SO/RDataX_DO                        read return, 1 cycle after grant
//   FlushReq_SI/InitDone_SO                     re-clear request / serving status
//   CSel_SO/WrEn_SO/BEn_SO/Addr_DO/WrData_DO    RAM control, active-high
//   RdData_DI                                   RAM read data
// ---------------------------------------------------------------------------
interface sram_share_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8
);
  localparam int BE_W = DATA_W / 8;

  logic              ReqA_SI,    ReqB_SI;
  logic              WeA_SI,     WeB_SI;
  logic [ADDR_W-1:0] AddrA_DI,   AddrB_DI;
  logic [DATA_W-1:0] WDataA_DI,  WDataB_DI;
  logic [BE_W-1:0]   BEnA_SI,    BEnB_SI;
  logic              GntA_SO,    GntB_SO;
  logic              RValidA_SO, RValidB_SO;
  logic [DATA_W-1:0] RDataA_DO,  RDataB_DO;
  logic              FlushReq_SI;
  logic              InitDone_SO;
  logic              CSel_SO,    WrEn_SO;
  logic [BE_W-1:0]   BEn_SO;
  logic [ADDR_W-1:0] Addr_DO;
  logic [DATA_W-1:0] WrData_DO;
  logic [DATA_W-1:0] RdData_DI;

  modport slave (
    input  ReqA_SI, ReqB_SI, WeA_SI, WeB_SI, AddrA_DI, AddrB_DI,
           WDataA_DI, WDataB_DI, BEnA_SI, BEnB_SI, FlushReq_SI, RdData_DI,
    output GntA_SO, GntB_SO, RValidA_SO, RValidB_SO, RDataA_DO, RDataB_DO,
           InitDone_SO, CSel_SO, WrEn_SO, BEn_SO, Addr_DO, WrData_DO
  );

  modport master (
    output ReqA_SI, ReqB_SI, WeA_SI, WeB_SI, AddrA_DI, AddrB_DI,
           WDataA_DI, WDataB_DI, BEnA_SI, BEnB_SI, FlushReq_SI, RdData_DI,
    input  GntA_SO, GntB_SO, RValidA_SO, RValidB_SO, RDataA_DO, RDataB_DO,
           InitDone_SO, CSel_SO, WrEn_SO, BEn_SO, Addr_DO, WrData_DO
  );
endinterface

// File: rtl/sram_share_arbiter.sv
// ---------------------------------------------------------------------------
// sram_share_arbiter
// Shares one synchronous single-port RAM (1-cycle read latency) between
// requester A (lookup) and requester B (refill/writeback) with a two-way
// round-robin, and routes read data back to whichever side issued the read.
//
// Ports:
//   Clk_CI   clock, rising edge
//   Rst_RBI  asynchronous active-low reset
//   bus      sram_share_arbiter_if.slave (requesters, flush/status, RAM pins)
//
// Build option ARB_INIT_CLEAR_EN:
//   defined   -> after reset and on FlushReq_SI the whole array is written to
//                zero (one word per cycle) before any requester is served.
//   undefined -> no sweep; the arbiter serves requests from the first cycle
//                and InitDone_SO is tied high.
// ---------------------------------------------------------------------------
module sram_share_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input logic                 Clk_CI,
  input logic                 Rst_RBI,
  sram_share_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;

  // The sweep counter wraps over the full address space.
  if (DEPTH != (1 << ADDR_W)) begin : g_depth_chk
    $error("sram_share_arbiter: DEPTH must equal 2**ADDR_W");
  end

  logic              ptr_q,    ptr_d;     // 0: A wins next contention, 1: B
  logic              rvalid_q, rvalid_d;  // a granted read returns this cycle
  logic              owner_q,  owner_d;   // 0: read belongs to A, 1: to B
  logic              run;                 // arbiter serving requests
  logic              flush;               // accepted flush, blocks grants
  logic              init_done;
  logic              win_b, gnt_a, gnt_b;
  logic              csel, wren;
  logic [BE_W-1:0]   ben;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;

`ifdef ARB_INIT_CLEAR_EN
  typedef enum logic {ST_INIT, ST_RUN} state_e;

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] cnt_q,       cnt_d;
  logic              init_done_q, init_done_d;

  assign run       = (state_q == ST_RUN);
  assign flush     = run & bus.FlushReq_SI;
  assign init_done = init_done_q;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Flush is only honoured while serving; a flush during the sweep is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end else if (bus.FlushReq_SI) begin
      state_d = ST_INIT;
      cnt_d   = '0;
    end
    // Registered so it rises together with the first serving cycle.
    init_done_d = (state_d == ST_RUN);
  end
`else
  logic unused_flush;

  assign run          = 1'b1;
  assign flush        = 1'b0;
  assign init_done    = 1'b1;
  assign unused_flush = bus.FlushReq_SI;
`endif

  always_comb begin
    // A lone requester always wins; the pointer only breaks ties.
    win_b = bus.ReqB_SI & (~bus.ReqA_SI | ptr_q);
    // Rst_RBI gating keeps grants and RAM pins quiet while reset is held,
    // even though the request inputs may already be active.
    gnt_a = Rst_RBI & run & ~flush & bus.ReqA_SI & ~win_b;
    gnt_b = Rst_RBI & run & ~flush & win_b;

    csel  = 1'b0;
    wren  = 1'b0;
    ben   = '0;
    addr  = '0;
    wdata = '0;
    if (gnt_a) begin
      csel  = 1'b1;
      wren  = bus.WeA_SI;
      ben   = bus.BEnA_SI;
      addr  = bus.AddrA_DI;
      wdata = bus.WDataA_DI;
    end else if (gnt_b) begin
      csel  = 1'b1;
      wren  = bus.WeB_SI;
      ben   = bus.BEnB_SI;
      addr  = bus.AddrB_DI;
      wdata = bus.WDataB_DI;
    end
`ifdef ARB_INIT_CLEAR_EN
    if (Rst_RBI && !run) begin
      csel  = 1'b1;
      wren  = 1'b1;
      ben   = '1;
      addr  = cnt_q;
      wdata = '0;
    end
`endif

    ptr_d = ptr_q;
    if (gnt_a)      ptr_d = 1'b1;
    else if (gnt_b) ptr_d = 1'b0;

    rvalid_d = (gnt_a & ~bus.WeA_SI) | (gnt_b & ~bus.WeB_SI);
    owner_d  = rvalid_d ? gnt_b : owner_q;
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      ptr_q    <= 1'b0;
      rvalid_q <= 1'b0;
      owner_q  <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      owner_q  <= owner_d;
    end
  end

  assign bus.GntA_SO     = gnt_a;
  assign bus.GntB_SO     = gnt_b;
  assign bus.RValidA_SO  = rvalid_q & ~owner_q;
  assign bus.RValidB_SO  = rvalid_q &  owner_q;
  // Both sides see the RAM output; RValid says whose it is.
  assign bus.RDataA_DO   = bus.RdData_DI;
  assign bus.RDataB_DO   = bus.RdData_DI;
  assign bus.InitDone_SO = init_done;
  assign bus.CSel_SO     = csel;
  assign bus.WrEn_SO     = wren;
  assign bus.BEn_SO      = ben;
  assign bus.Addr_DO     = addr;
  assign bus.WrData_DO   = wdata;
endmodule

// File: tb/tb_sram_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_share_arbiter
// Directed bench for sram_share_arbiter with a behavioural 256x64 RAM.
// Covers both builds; sweep-specific sequences exist only when
// ARB_INIT_CLEAR_EN is defined.
// ---------------------------------------------------------------------------
module tb_sram_share_arbiter;
`ifdef ARB_INIT_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  localparam logic [63:0] D0 = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] D1 = 64'h01234567_89ABCDEF;
  localparam logic [63:0] DX = 64'h11112222_33334444;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sram_share_arbiter_if #(.DATA_W(64), .ADDR_W(8)) bus ();

  sram_share_arbiter #(.DATA_W(64), .ADDR_W(8), .DEPTH(256)) dut (
    .Clk_CI  (clk),
    .Rst_RBI (rst_n),
    .bus     (bus)
  );

  // Pre-sweep RAM contents are nonzero so the zero sweep is observable.
  function automatic logic [63:0] pat(input int i);
    return {32'hA5A5A5A5, 24'h0, 8'(i)};
  endfunction

  function automatic logic [63:0] exp_base(input int i);
    return CLR ? 64'h0 : pat(i);
  endfunction

  // Behavioural RAM: byte-enabled write, registered read.
  logic [63:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = pat(i);

  always @(posedge clk) begin
    if (bus.CSel_SO) begin
      if (bus.WrEn_SO) begin
        for (int b = 0; b < 8; b++)
          if (bus.BEn_SO[b]) mem[bus.Addr_DO][b*8 +: 8] <= bus.WrData_DO[b*8 +: 8];
      end else begin
        bus.RdData_DI <= mem[bus.Addr_DO];
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_a(input logic r, input logic w, input logic [7:0] a,
                       input logic [63:0] d, input logic [7:0] be);
    bus.ReqA_SI = r; bus.WeA_SI = w; bus.AddrA_DI = a; bus.WDataA_DI = d; bus.BEnA_SI = be;
  endtask

  task automatic set_b(input logic r, input logic w, input logic [7:0] a,
                       input logic [63:0] d, input logic [7:0] be);
    bus.ReqB_SI = r; bus.WeB_SI = w; bus.AddrB_DI = a; bus.WDataB_DI = d; bus.BEnB_SI = be;
  endtask

  typedef struct {
    logic ra, wa; logic [7:0] aa; logic [63:0] da; logic [7:0] ba;
    logic rb, wb; logic [7:0] ab; logic [63:0] db; logic [7:0] bb;
    logic ga, gb, cs, we; logic [7:0] addr; logic [63:0] wd; logic [7:0] be;
    logic rva, rvb; logic [63:0] rd;
  } vec_t;

  vec_t tbl [15];

`ifdef ARB_INIT_CLEAR_EN
  // Entered at the negedge that starts sweep cycle 0, inputs already driven.
  task automatic do_sweep(input int stop_at);
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      bus.FlushReq_SI = (i == 50);
      #1;
      chk($sformatf("sweep%0d_addr", i), 64'(bus.Addr_DO), 64'(i));
      chk($sformatf("sweep%0d_ctl", i),
          64'({bus.CSel_SO, bus.WrEn_SO, bus.BEn_SO, bus.InitDone_SO, bus.GntA_SO, bus.GntB_SO}),
          64'({1'b1, 1'b1, 8'hFF, 3'b000}));
      chk($sformatf("sweep%0d_wd", i), bus.WrData_DO, 64'h0);
      if (i == stop_at) begin
        #1 rst_n = 1'b0;
        bus.FlushReq_SI = 1'b0;
        #1;
        chk("midsweep_rst", 64'({bus.CSel_SO, bus.WrEn_SO, bus.InitDone_SO, bus.Addr_DO}), 64'h0);
        return;
      end
    end
    @(negedge clk);
    bus.FlushReq_SI = 1'b0;
    #1;
    chk("sweep_done", 64'(bus.InitDone_SO), 64'h1);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] e20;
    e20 = (exp_base(8'h20) & 64'hFFFFFFFF_00000000) | (D1 & 64'h00000000_FFFFFFFF);

    //          ra    wa    aa     da     ba      rb    wb    ab     db     bb      ga    gb    cs    we    addr   wd     be      rva   rvb   rd
    tbl[0]  = '{1'b1, 1'b1, 8'h10, D0,    8'hFF,  1'b0, 1'b0, 8'h00, 64'h0, 8'h00,  1'b1, 1'b0, 1'b1, 1'b1, 8'h10, D0,    8'hFF,  1'b0, 1'b0, 64'h0};
    tbl[1]  = '{1'b1, 1'b0, 8'h10, 64'h0, 8'hFF,  1'b0, 1'b0, 8'h00, 64'h0, 8'h00,  1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 64'h0, 8'hFF,  1'b0, 1'b0, 64'h0};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 64'h0, 8'h00,  1'b0, 1'b0, 8'h00, 64'h0, 8'h00,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00,  1'b1, 1'b0, D0};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 64'h0, 8'h00,  1'b1, 1'b1, 8'h20, D1,    8'h0F,  1'b0, 1'b1, 1'b1, 1'b1, 8'h20, D1,    8'h0F,  1'b0, 1'b0, 64'h0};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 64'h0, 8'h00,  1'b1, 1'b0, 8'h20, 64'h0, 8'hFF,  1'b0, 1'b1, 1'b1, 1'b0, 8'h20, 64'h0, 8'hFF,  1'b0, 1'b0, 64'h0};
    tbl[5]  = '{1'b1, 1'b0, 8'h10, 64'h0, 8'hFF,  1'b1, 1'b0, 8'h20, 64'h0, 8'hFF,  1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 64'h0, 8'hFF,  1'b0, 1'b1, e20};
    tbl[6]  = '{1'b1, 1'b0, 8'h10, 64'h0, 8'hFF,  1'b1, 1'b0, 8'h20, 64'h0, 8'hFF,  1'b0, 1'b1, 1'b1, 1'b0, 8'h20, 64'h0, 8'hFF,  1'b1, 1'b0, D0};
    tbl[7]  = '{1'b1, 1'b0, 8'h10, 64'h0, 8'hFF,  1'b1, 1'b0, 8'h20, 64'h0, 8'hFF,  1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 64'h0, 8'hFF,  1'b0, 1'b1, e20};
    tbl[8]  = '{1'b1, 1'b0, 8'h10, 64'h0, 8'hFF,  1'b1, 1'b0, 8'h20, 64'h0, 8'hFF,  1'b0, 1'b1, 1'b1, 1'b0, 8'h20, 64'h0, 8'hFF,  1'b1, 1'b0, D0};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 64'h0, 8'h00,  1'b0, 1'b0, 8'h00, 64'h0, 8'h00,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00,  1'b0, 1'b1, e20};
    tbl[10] = '{1'b1, 1'b1, 8'h30, DX,    8'hFF,  1'b1, 1'b0, 8'h20, 64'h0, 8'hFF,  1'b1, 1'b0, 1'b1, 1'b1, 8'h30, DX,    8'hFF,  1'b0, 1'b0, 64'h0};
    tbl[11] = '{1'b1, 1'b0, 8'h30, 64'h0, 8'hFF,  1'b0, 1'b0, 8'h00, 64'h0, 8'h00,  1'b1, 1'b0, 1'b1, 1'b0, 8'h30, 64'h0, 8'hFF,  1'b0, 1'b0, 64'h0};
    tbl[12] = '{1'b1, 1'b0, 8'h30, 64'h0, 8'hFF,  1'b1, 1'b0, 8'h10, 64'h0, 8'hFF,  1'b0, 1'b1, 1'b1, 1'b0, 8'h10, 64'h0, 8'hFF,  1'b1, 1'b0, DX};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 64'h0, 8'h00,  1'b1, 1'b0, 8'h10, 64'h0, 8'hFF,  1'b0, 1'b1, 1'b1, 1'b0, 8'h10, 64'h0, 8'hFF,  1'b0, 1'b1, D0};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 64'h0, 8'h00,  1'b0, 1'b0, 8'h00, 64'h0, 8'h00,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00,  1'b0, 1'b1, D0};

    set_a(1'b0, 1'b0, 8'h0, 64'h0, 8'h0);
    set_b(1'b0, 1'b0, 8'h0, 64'h0, 8'h0);
    bus.FlushReq_SI = 1'b0;

    // Reset values, with one clock edge taken while reset is held.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctl", 64'({bus.GntA_SO, bus.GntB_SO, bus.RValidA_SO, bus.RValidB_SO, bus.CSel_SO, bus.WrEn_SO}), 64'h0);
    chk("rst_done", 64'(bus.InitDone_SO), 64'(!CLR));
    chk("rst_pins", 64'({bus.BEn_SO, bus.Addr_DO}), 64'h0);
    chk("rst_wd", bus.WrData_DO, 64'h0);

`ifdef ARB_INIT_CLEAR_EN
    @(negedge clk);
    rst_n = 1'b1;
    do_sweep(256);
    // Swept location reads back as zero.
    @(negedge clk);
    set_a(1'b1, 1'b0, 8'h7F, 64'h0, 8'hFF);
    #1;
    chk("rd7f_gnt", 64'({bus.GntA_SO, bus.CSel_SO, bus.Addr_DO}), 64'({1'b1, 1'b1, 8'h7F}));
    @(negedge clk);
    set_a(1'b0, 1'b0, 8'h0, 64'h0, 8'h0);
    #1;
    chk("rd7f_rv", 64'({bus.RValidA_SO, bus.RValidB_SO}), 64'b10);
    chk("rd7f_data", bus.RDataA_DO, 64'h0);
`else
    // Serving from the very first cycle after release.
    @(negedge clk);
    rst_n = 1'b1;
    set_a(1'b1, 1'b0, 8'h05, 64'h0, 8'hFF);
    #1;
    chk("rd05_gnt", 64'({bus.GntA_SO, bus.CSel_SO, bus.WrEn_SO, bus.Addr_DO}), 64'({1'b1, 1'b1, 1'b0, 8'h05}));
    @(negedge clk);
    set_a(1'b0, 1'b0, 8'h0, 64'h0, 8'h0);
    #1;
    chk("rd05_rv", 64'({bus.RValidA_SO, bus.RValidB_SO}), 64'b10);
    chk("rd05_data", bus.RDataA_DO, pat(5));
`endif

    // Arbitration / read-return table; pointer enters pointing at B.
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      set_a(tbl[k].ra, tbl[k].wa, tbl[k].aa, tbl[k].da, tbl[k].ba);
      set_b(tbl[k].rb, tbl[k].wb, tbl[k].ab, tbl[k].db, tbl[k].bb);
      #1;
      chk($sformatf("v%0d_gnt", k), 64'({bus.GntA_SO, bus.GntB_SO}), 64'({tbl[k].ga, tbl[k].gb}));
      chk($sformatf("v%0d_cswe", k), 64'({bus.CSel_SO, bus.WrEn_SO}), 64'({tbl[k].cs, tbl[k].we}));
      chk($sformatf("v%0d_addr", k), 64'(bus.Addr_DO), 64'(tbl[k].addr));
      chk($sformatf("v%0d_wd", k), bus.WrData_DO, tbl[k].wd);
      chk($sformatf("v%0d_be", k), 64'(bus.BEn_SO), 64'(tbl[k].be));
      chk($sformatf("v%0d_rv", k), 64'({bus.RValidA_SO, bus.RValidB_SO}), 64'({tbl[k].rva, tbl[k].rvb}));
      if (tbl[k].rva || tbl[k].rvb) begin
        chk($sformatf("v%0d_rda", k), bus.RDataA_DO, tbl[k].rd);
        chk($sformatf("v%0d_rdb", k), bus.RDataB_DO, tbl[k].rd);
      end
    end

`ifdef ARB_INIT_CLEAR_EN
    // Flush right after a granted read: read still returns, then a full sweep,
    // and the waiting B request is served only once InitDone rises.
    @(negedge clk);
    set_a(1'b1, 1'b0, 8'h20, 64'h0, 8'hFF);
    #1;
    chk("fl_rd_gnt", 64'({bus.GntA_SO, bus.GntB_SO}), 64'b10);
    @(negedge clk);
    set_a(1'b0, 1'b0, 8'h0, 64'h0, 8'h0);
    set_b(1'b1, 1'b0, 8'h10, 64'h0, 8'hFF);
    bus.FlushReq_SI = 1'b1;
    #1;
    chk("fl_nogrant", 64'({bus.GntA_SO, bus.GntB_SO, bus.CSel_SO}), 64'h0);
    chk("fl_rv", 64'({bus.RValidA_SO, bus.RValidB_SO}), 64'b10);
    chk("fl_rdata", bus.RDataA_DO, e20);
    chk("fl_done_hold", 64'(bus.InitDone_SO), 64'h1);
    @(negedge clk);
    bus.FlushReq_SI = 1'b0;
    do_sweep(256);
    chk("fl_b_gnt", 64'({bus.GntA_SO, bus.GntB_SO, bus.Addr_DO}), 64'({1'b0, 1'b1, 8'h10}));
    @(negedge clk);
    set_b(1'b0, 1'b0, 8'h0, 64'h0, 8'h0);
    #1;
    chk("fl_b_rv", 64'({bus.RValidA_SO, bus.RValidB_SO}), 64'b01);
    chk("fl_b_data", bus.RDataB_DO, 64'h0);

    // Reset pulsed at sweep address 100 restarts the sweep from 0.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("run_rst", 64'({bus.CSel_SO, bus.InitDone_SO, bus.Addr_DO}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_sweep(100);
    @(negedge clk);
    rst_n = 1'b1;
    do_sweep(256);
`else
    // Flush has no effect: grant still issued, InitDone stays high.
    @(negedge clk);
    set_a(1'b1, 1'b0, 8'h30, 64'h0, 8'hFF);
    set_b(1'b1, 1'b0, 8'h10, 64'h0, 8'hFF);
    bus.FlushReq_SI = 1'b1;
    #1;
    chk("nofl_gnt", 64'({bus.GntA_SO, bus.GntB_SO, bus.CSel_SO}), 64'b101);
    chk("nofl_done", 64'(bus.InitDone_SO), 64'h1);
    @(negedge clk);
    set_a(1'b0, 1'b0, 8'h0, 64'h0, 8'h0);
    set_b(1'b0, 1'b0, 8'h0, 64'h0, 8'h0);
    bus.FlushReq_SI = 1'b0;
    #1;
    chk("nofl_done2", 64'(bus.InitDone_SO), 64'h1);
    chk("nofl_rv", 64'({bus.RValidA_SO, bus.RValidB_SO}), 64'b10);
    chk("nofl_data", bus.RDataA_DO, DX);
`endif

    // Reset between a read grant and its return drops the response.
    @(negedge clk);
    set_a(1'b1, 1'b0, 8'h10, 64'h0, 8'hFF);
    #1;
    chk("mr_gnt", 64'(bus.GntA_SO), 64'h1);
    #2 rst_n = 1'b0;
    set_a(1'b0, 1'b0, 8'h0, 64'h0, 8'h0);
    @(negedge clk);
    #1;
    chk("mr_lost", 64'({bus.RValidA_SO, bus.RValidB_SO, bus.CSel_SO}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef ARB_INIT_CLEAR_EN
    do_sweep(256);
`else
    #1;
    chk("mr_done", 64'(bus.InitDone_SO), 64'h1);
`endif
    @(negedge clk);
    #1;
    chk("mr_after", 64'({bus.RValidA_SO, bus.RValidB_SO}), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
